// File: rtl/conv_core_prewitt3x3.sv
// conv_core_prewitt3x3: three-stage pipelined 3x3 signed-kernel convolution on unsigned pixels with coordinate alignment
module conv_core_prewitt3x3 #(
  parameter int X_W = 11,
  parameter int Y_W = 10,
  parameter logic signed [7:0] K00 = -8'sd1,
  parameter logic signed [7:0] K01 = 8'sd0,
  parameter logic signed [7:0] K02 = 8'sd1,
  parameter logic signed [7:0] K10 = -8'sd1,
  parameter logic signed [7:0] K11 = 8'sd0,
  parameter logic signed [7:0] K12 = 8'sd1,
  parameter logic signed [7:0] K20 = -8'sd1,
  parameter logic signed [7:0] K21 = 8'sd0,
  parameter logic signed [7:0] K22 = 8'sd1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               window_valid,
  input  logic               fsm_window_valid,
  input  logic [X_W-1:0]     x,
  input  logic [Y_W-1:0]     y,
  input  logic [7:0]         w00,
  input  logic [7:0]         w01,
  input  logic [7:0]         w02,
  input  logic [7:0]         w10,
  input  logic [7:0]         w11,
  input  logic [7:0]         w12,
  input  logic [7:0]         w20,
  input  logic [7:0]         w21,
  input  logic [7:0]         w22,
  output logic signed [19:0] conv_out,
  output logic               conv_valid,
  output logic [X_W-1:0]     x_regcc,
  output logic [Y_W-1:0]     y_regcc
);
  localparam logic [8:0][7:0] K = {K22, K21, K20, K12, K11, K10, K02, K01, K00};
  logic [8:0][7:0]  w_in, w1;
  logic [8:0][16:0] p, p2;
  logic [19:0]      sum;
  logic [X_W-1:0]   x1, x2;
  logic [Y_W-1:0]   y1, y2;
  logic             acc, v1, v2;
  assign w_in = {w22, w21, w20, w12, w11, w10, w02, w01, w00};
  assign acc  = window_valid & fsm_window_valid;
  always_comb begin
    for (int i = 0; i < 9; i++) p[i] = {9'b0, w1[i]} * {{9{K[i][7]}}, K[i]};
  end
  always_comb begin
    sum = '0;
    for (int i = 0; i < 9; i++) sum = sum + {{3{p2[i][16]}}, p2[i]};
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1         <= 1'b0;
      v2         <= 1'b0;
      conv_valid <= 1'b0;
      w1         <= '0;
      x1         <= '0;
      y1         <= '0;
      p2         <= '0;
      x2         <= '0;
      y2         <= '0;
      conv_out   <= '0;
      x_regcc    <= '0;
      y_regcc    <= '0;
    end else begin
      v1         <= acc;
      v2         <= v1;
      conv_valid <= v2;
      if (acc) begin
        w1 <= w_in;
        x1 <= x;
        y1 <= y;
      end
      if (v1) begin
        p2 <= p;
        x2 <= x1;
        y2 <= y1;
      end
      if (v2) begin
        conv_out <= sum;
        x_regcc  <= x2;
        y_regcc  <= y2;
      end
    end
  end
endmodule

// File: tb/tb_conv_core_prewitt3x3.sv
// tb_conv_core_prewitt3x3: directed self-checking bench for the 3x3 convolution core
module tb_conv_core_prewitt3x3;
  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               window_valid = 1'b0;
  logic               fsm_window_valid = 1'b0;
  logic [10:0]        x = '0;
  logic [9:0]         y = '0;
  logic [7:0]         w00 = '0, w01 = '0, w02 = '0;
  logic [7:0]         w10 = '0, w11 = '0, w12 = '0;
  logic [7:0]         w20 = '0, w21 = '0, w22 = '0;
  logic signed [19:0] conv_out;
  logic               conv_valid;
  logic [10:0]        x_regcc;
  logic [9:0]         y_regcc;
  int                 checks = 0;
  int                 errors = 0;
  int                 waited;

  conv_core_prewitt3x3 dut (
    .clk(clk), .reset(reset),
    .window_valid(window_valid), .fsm_window_valid(fsm_window_valid),
    .x(x), .y(y),
    .w00(w00), .w01(w01), .w02(w02),
    .w10(w10), .w11(w11), .w12(w12),
    .w20(w20), .w21(w21), .w22(w22),
    .conv_out(conv_out), .conv_valid(conv_valid),
    .x_regcc(x_regcc), .y_regcc(y_regcc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setw(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2);
    w00 = c0; w10 = c0; w20 = c0;
    w01 = c1; w11 = c1; w21 = c1;
    w02 = c2; w12 = c2; w22 = c2;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic signed [31:0] o,
                         input logic [31:0] ex, input logic [31:0] ey);
    chk({tag, "_valid"}, conv_valid, v);
    chk({tag, "_out"}, conv_out, o);
    chk({tag, "_x"}, x_regcc, ex);
    chk({tag, "_y"}, y_regcc, ey);
  endtask

  initial begin
    #20;
    chk_out("reset_hold", 1'b0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    step();
    step();
    chk_out("post_release", 1'b0, 0, 0, 0);

    setw(8'd200, 8'd0, 8'd10);
    x = 11'd100; y = 10'd100;
    window_valid = 1'b1; fsm_window_valid = 1'b1;
    step();
    step();
    chk("latency_early_valid", conv_valid, 1'b0);
    waited = 0;
    while (!conv_valid && waited < 5) begin
      step();
      waited++;
    end
    chk("latency_edges", waited, 1);
    chk_out("grad", 1'b1, -570, 100, 100);

    fsm_window_valid = 1'b0;
    setw(8'd77, 8'd77, 8'd77);
    x = 11'd33; y = 10'd44;
    step();
    step();
    for (int i = 0; i < 8; i++) begin
      step();
      chk_out("gate_fsm", 1'b0, -570, 100, 100);
    end
    window_valid = 1'b0; fsm_window_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk_out("gate_win", 1'b0, -570, 100, 100);
    end

    window_valid = 1'b1; fsm_window_valid = 1'b1;
    x = 11'd50; y = 10'd60;
    step();
    step();
    step();
    chk_out("uniform", 1'b1, 0, 50, 60);

    setw(8'd0, 8'd123, 8'd255);
    x = 11'd5; y = 10'd7;
    step();
    setw(8'd255, 8'd123, 8'd0);
    x = 11'd6;
    step();
    window_valid = 1'b0;
    step();
    chk_out("edge_pos", 1'b1, 765, 5, 7);
    step();
    chk_out("edge_neg", 1'b1, -765, 6, 7);
    step();
    chk_out("edge_hold", 1'b0, -765, 6, 7);

    setw(8'd200, 8'd0, 8'd10);
    x = 11'd9; y = 10'd9;
    window_valid = 1'b1;
    step();
    window_valid = 1'b0;
    step();
    reset = 1'b0;
    #1;
    chk_out("async_reset", 1'b0, 0, 0, 0);
    step();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_out("no_spurious", 1'b0, 0, 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
